// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit 7-segment scan driver with frame-aligned double-buffered loads.
// Loads land in a staging buffer and move to the displayed shadow only at a frame boundary.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                      CLOCK_50_i,
  input  logic                      RESET_i,
  input  logic [4*NUM_DIGITS-1:0]   data_i,
  input  logic [NUM_DIGITS-1:0]     digit_en_i,
  input  logic                      load_i,
  output logic                      load_ack_o,
  output logic                      frame_o,
  output logic [NUM_DIGITS-1:0]     an_o,
  output logic                      ca_o,
  output logic                      cb_o,
  output logic                      cc_o,
  output logic                      cd_o,
  output logic                      ce_o,
  output logic                      cf_o,
  output logic                      cg_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Active-low segment pattern, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [PW-1:0]             presc;
  logic [IW-1:0]             idx;
  logic                      tick;
  logic                      frame_tick;
  logic [4*NUM_DIGITS-1:0]   staging_data;
  logic [NUM_DIGITS-1:0]     staging_en;
  logic                      pending;
  logic [4*NUM_DIGITS-1:0]   shadow_data;
  logic [NUM_DIGITS-1:0]     shadow_en;
  logic [3:0]                cur_nib;
  logic                      cur_en;
  logic [NUM_DIGITS-1:0]     an_p1;
  logic [6:0]                seg_p1;
  logic                      ack_p1;
  logic                      frame_p1;

  always_comb begin
    tick       = (presc == PRESC_LAST);
    frame_tick = tick && (idx == IDX_LAST);
    cur_nib    = shadow_data[4*idx +: 4];
    cur_en     = shadow_en[idx];
  end

  // Scan timing: prescaler and digit index
  always_ff @(posedge CLOCK_50_i) begin
    if (RESET_i) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Load handshake: staging -> shadow only on frame_tick; a same-cycle load bypasses staging
  always_ff @(posedge CLOCK_50_i) begin
    if (RESET_i) begin
      staging_data <= '0;
      staging_en   <= '0;
      pending      <= 1'b0;
      shadow_data  <= '0;
      shadow_en    <= '0;
      ack_p1       <= 1'b0;
    end else begin
      ack_p1 <= 1'b0;
      if (frame_tick) begin
        if (load_i) begin
          shadow_data <= data_i;
          shadow_en   <= digit_en_i;
          ack_p1      <= 1'b1;
        end else if (pending) begin
          shadow_data <= staging_data;
          shadow_en   <= staging_en;
          ack_p1      <= 1'b1;
        end
        pending <= 1'b0;
      end else if (load_i) begin
        staging_data <= data_i;
        staging_en   <= digit_en_i;
        pending      <= 1'b1;
      end
    end
  end

  // Output stage: registered from current (idx, shadow), one cycle behind idx
  always_ff @(posedge CLOCK_50_i) begin
    if (RESET_i) begin
      an_p1    <= '1;
      seg_p1   <= '1;
      frame_p1 <= 1'b0;
    end else begin
      frame_p1 <= frame_tick;
      if (cur_en) begin
        an_p1  <= ~(NUM_DIGITS'(1) << idx);
        seg_p1 <= hex_to_seg(cur_nib);
      end else begin
        an_p1  <= '1;
        seg_p1 <= '1;
      end
    end
  end

  assign an_o       = an_p1;
  assign load_ack_o = ack_p1;
  assign frame_o    = frame_p1;
  assign {ca_o, cb_o, cc_o, cd_o, ce_o, cf_o, cg_o} = seg_p1;

endmodule
